// File: rtl/am_query_arbiter.sv
// am_query_arbiter
//   Shares one associative memory (AM) between NUM_REQ query sources. One
//   query is accepted at a time (round-robin from a rotating priority pointer),
//   driven into the AM, and the AM result is returned tagged with the index of
//   the requester that issued it. Exactly one transaction is in flight.
//
// Ports
//   Clk_CI, Reset_RI                 clock, synchronous active-high reset
//   ReqValid_SI / ReqReady_SO        per-requester query handshake (ready is one-hot)
//   ReqHypervector_DI                requester i at [i*HV_DIMENSION +: HV_DIMENSION]
//   AmValid_SO / AmReady_SI          query handshake towards the AM
//   AmHypervector_DO                 query hypervector towards the AM
//   AmValid_SI / AmReady_SO          result handshake from the AM
//   AmLabel_*_DI, AmDistance_*_DI    AM result (A and V)
//   RespValid_SO / RespReady_SI      tagged result handshake towards the consumer
//   RespId_DO                        index of the requester owning the result
//   RespLabel_*_DO, RespDistance_*_DO registered AM result
//   Busy_SO                          high whenever a transaction is in progress

module am_query_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned HV_DIMENSION   = 2000,
  parameter int unsigned LABEL_WIDTH    = 1,
  parameter int unsigned DISTANCE_WIDTH = 11,
  parameter int unsigned ID_WIDTH       = 2
) (
  input  logic                             Clk_CI,
  input  logic                             Reset_RI,

  input  logic [NUM_REQ-1:0]               ReqValid_SI,
  output logic [NUM_REQ-1:0]               ReqReady_SO,
  input  logic [NUM_REQ*HV_DIMENSION-1:0]  ReqHypervector_DI,

  output logic                             AmValid_SO,
  input  logic                             AmReady_SI,
  output logic [HV_DIMENSION-1:0]          AmHypervector_DO,

  input  logic                             AmValid_SI,
  output logic                             AmReady_SO,
  input  logic [LABEL_WIDTH-1:0]           AmLabel_A_DI,
  input  logic [LABEL_WIDTH-1:0]           AmLabel_V_DI,
  input  logic [DISTANCE_WIDTH-1:0]        AmDistance_A_DI,
  input  logic [DISTANCE_WIDTH-1:0]        AmDistance_V_DI,

  output logic                             RespValid_SO,
  input  logic                             RespReady_SI,
  output logic [ID_WIDTH-1:0]              RespId_DO,
  output logic [LABEL_WIDTH-1:0]           RespLabel_A_DO,
  output logic [LABEL_WIDTH-1:0]           RespLabel_V_DO,
  output logic [DISTANCE_WIDTH-1:0]        RespDistance_A_DO,
  output logic [DISTANCE_WIDTH-1:0]        RespDistance_V_DO,

  output logic                             Busy_SO
);

  typedef enum logic [1:0] {
    Idle       = 2'd0,
    Issue      = 2'd1,
    WaitResult = 2'd2,
    Respond    = 2'd3
  } state_t;

  state_t State_SP, State_SN;

  logic [ID_WIDTH-1:0]       Ptr_DP;
  logic [ID_WIDTH-1:0]       IdReg_DP;
  logic [HV_DIMENSION-1:0]   QueryReg_DP;

  logic                      GrantValid_S;
  logic [ID_WIDTH-1:0]       GrantIdx_D;
  logic [NUM_REQ-1:0]        GrantOneHot_S;
  logic [ID_WIDTH-1:0]       NextPtr_D;
  logic [HV_DIMENSION-1:0]   SelHv_D;

  logic                      LoadQuery_S;
  logic                      LoadResp_S;

  // ---------------------------------------------------------------------------
  // Round-robin grant search starting at Ptr_DP.
  // The first pass picks the lowest valid index overall (the wrapped-around
  // candidate); the second pass overrides it with the lowest valid index at or
  // above the pointer, if one exists.
  // ---------------------------------------------------------------------------
  always_comb begin
    GrantValid_S  = 1'b0;
    GrantIdx_D    = '0;
    GrantOneHot_S = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (ReqValid_SI[i]) begin
        GrantValid_S = 1'b1;
        GrantIdx_D   = ID_WIDTH'(i);
      end
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (ReqValid_SI[i] && (ID_WIDTH'(i) >= Ptr_DP)) begin
        GrantIdx_D = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      GrantOneHot_S[i] = GrantValid_S && (GrantIdx_D == ID_WIDTH'(i));
    end
  end

  // Pointer moves just past the granted requester, wrapping at NUM_REQ.
  assign NextPtr_D = (GrantIdx_D == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                            : GrantIdx_D + ID_WIDTH'(1);

  // Hypervector of the granted requester (constant part-selects only).
  always_comb begin
    SelHv_D = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (GrantIdx_D == ID_WIDTH'(i)) begin
        SelHv_D = ReqHypervector_DI[i*HV_DIMENSION +: HV_DIMENSION];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      State_SP <= Idle;
    end else begin
      State_SP <= State_SN;
    end
  end

  // FSM: next-state logic
  always_comb begin
    State_SN = State_SP;
    unique case (State_SP)
      Idle: begin
        if (GrantValid_S) begin
          State_SN = Issue;
        end
      end
      Issue: begin
        if (AmReady_SI) begin
          State_SN = WaitResult;
        end
      end
      WaitResult: begin
        if (AmValid_SI) begin
          State_SN = Respond;
        end
      end
      Respond: begin
        if (RespReady_SI) begin
          State_SN = Idle;
        end
      end
      default: State_SN = Idle;
    endcase
  end

  // FSM: outputs and register load strobes, decoded from the current state
  always_comb begin
    ReqReady_SO  = '0;
    AmValid_SO   = 1'b0;
    AmReady_SO   = 1'b0;
    RespValid_SO = 1'b0;
    Busy_SO      = 1'b1;
    LoadQuery_S  = 1'b0;
    LoadResp_S   = 1'b0;
    unique case (State_SP)
      Idle: begin
        Busy_SO     = 1'b0;
        ReqReady_SO = GrantOneHot_S;
        LoadQuery_S = GrantValid_S;
      end
      Issue: begin
        AmValid_SO = 1'b1;
      end
      WaitResult: begin
        AmReady_SO = 1'b1;
        LoadResp_S = AmValid_SI;
      end
      Respond: begin
        RespValid_SO = 1'b1;
      end
      default: begin
        Busy_SO = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: pointer, captured query and tag, captured AM result
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      Ptr_DP            <= '0;
      IdReg_DP          <= '0;
      QueryReg_DP       <= '0;
      RespId_DO         <= '0;
      RespLabel_A_DO    <= '0;
      RespLabel_V_DO    <= '0;
      RespDistance_A_DO <= '0;
      RespDistance_V_DO <= '0;
    end else begin
      if (LoadQuery_S) begin
        Ptr_DP      <= NextPtr_D;
        IdReg_DP    <= GrantIdx_D;
        QueryReg_DP <= SelHv_D;
      end
      if (LoadResp_S) begin
        RespId_DO         <= IdReg_DP;
        RespLabel_A_DO    <= AmLabel_A_DI;
        RespLabel_V_DO    <= AmLabel_V_DI;
        RespDistance_A_DO <= AmDistance_A_DI;
        RespDistance_V_DO <= AmDistance_V_DI;
      end
    end
  end

  // Query register is visible in every state; only meaningful with AmValid_SO.
  assign AmHypervector_DO = QueryReg_DP;

endmodule

// File: tb/tb_am_query_arbiter.sv
// Directed bench for am_query_arbiter: expected responses are queued when the
// AM result is driven and compared when the arbiter presents its response.
module tb_am_query_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned HV = 2000;
  localparam int unsigned LW = 1;
  localparam int unsigned DW = 11;
  localparam int unsigned IW = 2;

  logic                 Clk_CI;
  logic                 Reset_RI;
  logic [NR-1:0]        ReqValid_SI;
  logic [NR-1:0]        ReqReady_SO;
  logic [NR*HV-1:0]     ReqHypervector_DI;
  logic                 AmValid_SO;
  logic                 AmReady_SI;
  logic [HV-1:0]        AmHypervector_DO;
  logic                 AmValid_SI;
  logic                 AmReady_SO;
  logic [LW-1:0]        AmLabel_A_DI, AmLabel_V_DI;
  logic [DW-1:0]        AmDistance_A_DI, AmDistance_V_DI;
  logic                 RespValid_SO;
  logic                 RespReady_SI;
  logic [IW-1:0]        RespId_DO;
  logic [LW-1:0]        RespLabel_A_DO, RespLabel_V_DO;
  logic [DW-1:0]        RespDistance_A_DO, RespDistance_V_DO;
  logic                 Busy_SO;

  am_query_arbiter #(
    .NUM_REQ(NR), .HV_DIMENSION(HV), .LABEL_WIDTH(LW),
    .DISTANCE_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .Clk_CI(Clk_CI), .Reset_RI(Reset_RI),
    .ReqValid_SI(ReqValid_SI), .ReqReady_SO(ReqReady_SO),
    .ReqHypervector_DI(ReqHypervector_DI),
    .AmValid_SO(AmValid_SO), .AmReady_SI(AmReady_SI),
    .AmHypervector_DO(AmHypervector_DO),
    .AmValid_SI(AmValid_SI), .AmReady_SO(AmReady_SO),
    .AmLabel_A_DI(AmLabel_A_DI), .AmLabel_V_DI(AmLabel_V_DI),
    .AmDistance_A_DI(AmDistance_A_DI), .AmDistance_V_DI(AmDistance_V_DI),
    .RespValid_SO(RespValid_SO), .RespReady_SI(RespReady_SI),
    .RespId_DO(RespId_DO),
    .RespLabel_A_DO(RespLabel_A_DO), .RespLabel_V_DO(RespLabel_V_DO),
    .RespDistance_A_DO(RespDistance_A_DO), .RespDistance_V_DO(RespDistance_V_DO),
    .Busy_SO(Busy_SO)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [LW-1:0] la;
    logic [LW-1:0] lv;
    logic [DW-1:0] da;
    logic [DW-1:0] dv;
  } resp_t;

  resp_t         expQ[$];
  logic [HV-1:0] hvTab [NR];
  logic [NR-1:0] pending;
  int            checkCnt = 0;
  int            passCnt  = 0;
  int            failCnt  = 0;

  initial Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCnt++;
    assert (obs === expv) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkHv(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] expv);
    checkCnt++;
    assert (obs === expv) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed(low32)=%0h expected(low32)=%0h", tag, obs[31:0], expv[31:0]);
    end
  endtask

  // Inputs change right after the falling edge; checks follow #1 later.
  task automatic cyc();
    @(negedge Clk_CI);
  endtask

  task automatic checkResp();
    resp_t e;
    check("resp_valid", 32'(RespValid_SO), 32'd1);
    check("resp_req_ready", 32'(ReqReady_SO), 32'd0);
    if (expQ.size() == 0) begin
      check("sb_underflow", 32'(expQ.size()), 32'd1);
    end else begin
      e = expQ[0];
      check("resp_id",  32'(RespId_DO),         32'(e.id));
      check("resp_la",  32'(RespLabel_A_DO),    32'(e.la));
      check("resp_lv",  32'(RespLabel_V_DO),    32'(e.lv));
      check("resp_da",  32'(RespDistance_A_DO), 32'(e.da));
      check("resp_dv",  32'(RespDistance_V_DO), 32'(e.dv));
    end
  endtask

  // IDLE cycle: add new requesters, expect one-hot grant.
  task automatic grantPhase(input logic [NR-1:0] newReq, input int g);
    cyc();
    pending      = pending | newReq;
    ReqValid_SI  = pending;
    RespReady_SI = 1'b0;
    AmValid_SI   = 1'b0;
    AmReady_SI   = 1'b0;
    #1;
    check("grant_ready", 32'(ReqReady_SO), 32'(1) << g);
    check("idle_busy", 32'(Busy_SO), 32'd0);
    check("idle_am_valid", 32'(AmValid_SO), 32'd0);
    pending[g] = 1'b0;
  endtask

  // ISSUE: optional AM stall with a stray AM result that must be ignored.
  task automatic issuePhase(input int g, input int stall);
    cyc();
    ReqValid_SI = pending;
    for (int s = 0; s < stall; s++) begin
      AmReady_SI      = 1'b0;
      AmValid_SI      = 1'b1;
      AmLabel_A_DI    = '1;
      AmLabel_V_DI    = '1;
      AmDistance_A_DI = '1;
      AmDistance_V_DI = '1;
      #1;
      check("stall_am_valid", 32'(AmValid_SO), 32'd1);
      checkHv("stall_hv", AmHypervector_DO, hvTab[g]);
      check("stall_req_ready", 32'(ReqReady_SO), 32'd0);
      check("stall_am_ready", 32'(AmReady_SO), 32'd0);
      cyc();
    end
    AmValid_SI = 1'b0;
    AmReady_SI = 1'b1;
    #1;
    check("issue_am_valid", 32'(AmValid_SO), 32'd1);
    checkHv("issue_hv", AmHypervector_DO, hvTab[g]);
    check("issue_busy", 32'(Busy_SO), 32'd1);
  endtask

  // WAIT_RESULT: AM compute delay, then drive the result and queue expectation.
  task automatic waitPhase(input int g, input int la, input int lv,
                           input int da, input int dv, input int delay);
    resp_t e;
    cyc();
    AmReady_SI = 1'b0;
    for (int d = 0; d < delay; d++) begin
      #1;
      check("wait_am_ready", 32'(AmReady_SO), 32'd1);
      check("wait_resp_valid", 32'(RespValid_SO), 32'd0);
      cyc();
    end
    AmValid_SI      = 1'b1;
    AmLabel_A_DI    = LW'(la);
    AmLabel_V_DI    = LW'(lv);
    AmDistance_A_DI = DW'(da);
    AmDistance_V_DI = DW'(dv);
    e.id = IW'(g);
    e.la = LW'(la);
    e.lv = LW'(lv);
    e.da = DW'(da);
    e.dv = DW'(dv);
    expQ.push_back(e);
    #1;
    check("wait_am_ready", 32'(AmReady_SO), 32'd1);
    check("wait_am_valid", 32'(AmValid_SO), 32'd0);
  endtask

  // RESPOND: consumer stall, with stray AM results that must not disturb data.
  task automatic respPhase(input int stall);
    cyc();
    AmValid_SI      = 1'b1;
    AmDistance_A_DI = DW'($urandom);
    AmDistance_V_DI = DW'($urandom);
    RespReady_SI    = 1'b0;
    for (int s = 0; s < stall; s++) begin
      #1;
      checkResp();
      cyc();
    end
    RespReady_SI = 1'b1;
    #1;
    checkResp();
    if (expQ.size() != 0) void'(expQ.pop_front());
  endtask

  task automatic txn(input logic [NR-1:0] newReq, input int g,
                     input int la, input int lv, input int da, input int dv,
                     input int amStall, input int amDelay, input int respStall);
    grantPhase(newReq, g);
    issuePhase(g, amStall);
    waitPhase(g, la, lv, da, dv, amDelay);
    respPhase(respStall);
  endtask

  initial begin
    Reset_RI        = 1'b1;
    ReqValid_SI     = '0;
    AmReady_SI      = 1'b0;
    AmValid_SI      = 1'b0;
    RespReady_SI    = 1'b0;
    AmLabel_A_DI    = '0;
    AmLabel_V_DI    = '0;
    AmDistance_A_DI = '0;
    AmDistance_V_DI = '0;
    pending         = '0;
    for (int i = 0; i < int'(NR); i++) begin
      for (int b = 0; b < int'(HV); b++) hvTab[i][b] = 1'($urandom);
      ReqHypervector_DI[i*HV +: HV] = hvTab[i];
    end

    // Reset values
    cyc();
    cyc();
    #1;
    check("rst_busy", 32'(Busy_SO), 32'd0);
    check("rst_am_valid", 32'(AmValid_SO), 32'd0);
    check("rst_am_ready", 32'(AmReady_SO), 32'd0);
    check("rst_resp_valid", 32'(RespValid_SO), 32'd0);
    check("rst_req_ready", 32'(ReqReady_SO), 32'd0);
    check("rst_resp_id", 32'(RespId_DO), 32'd0);
    check("rst_resp_da", 32'(RespDistance_A_DO), 32'd0);
    checkHv("rst_query", AmHypervector_DO, '0);
    cyc();
    Reset_RI = 1'b0;

    // Single request from requester 1 (Ptr -> 2)
    txn(3'b010, 1, 1, 0, 412, 530, 0, 2, 0);
    // Fairness: {0,1} with Ptr=2 -> 0 then 1
    txn(3'b011, 0, 0, 1, 17, 1999, 0, 1, 0);
    txn(3'b000, 1, 1, 1, 2047, 0, 0, 0, 0);
    // AM backpressure on a lone requester 2 (Ptr 2 -> 0)
    txn(3'b100, 2, 0, 0, 100, 200, 5, 0, 0);
    // Response backpressure with requester 1 waiting
    txn(3'b011, 0, 1, 0, 333, 444, 0, 1, 4);
    txn(3'b000, 1, 0, 1, 5, 6, 1, 0, 0);

    // Reset while idle, then three simultaneous held requests: 0, 1, 2
    cyc();
    Reset_RI = 1'b1;
    cyc();
    Reset_RI = 1'b0;
    txn(3'b111, 0, 1, 1, 11, 22, 0, 0, 0);
    txn(3'b000, 1, 0, 0, 33, 44, 0, 0, 1);
    txn(3'b000, 2, 1, 0, 55, 66, 0, 3, 0);

    // Reset in WAIT_RESULT after granting requester 1 (Ptr would be 2)
    grantPhase(3'b010, 1);
    issuePhase(1, 0);
    cyc();
    AmReady_SI      = 1'b0;
    Reset_RI        = 1'b1;
    AmValid_SI      = 1'b1;
    AmDistance_A_DI = DW'(777);
    #1;
    check("rstw_am_ready", 32'(AmReady_SO), 32'd1);
    cyc();
    Reset_RI   = 1'b0;
    AmValid_SI = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rstw_busy", 32'(Busy_SO), 32'd0);
      check("rstw_resp_valid", 32'(RespValid_SO), 32'd0);
      check("rstw_resp_da", 32'(RespDistance_A_DO), 32'd0);
      cyc();
    end
    // Ptr back at 0: {1,2} grants requester 1
    txn(3'b110, 1, 1, 0, 9, 10, 0, 0, 0);
    txn(3'b000, 2, 0, 1, 12, 13, 0, 0, 0);

    cyc();
    RespReady_SI = 1'b0;
    #1;
    check("final_busy", 32'(Busy_SO), 32'd0);
    check("sb_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
